// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry framer: FSM state encoding,
// default sync header bytes and the bytes-per-channel helper.
package telemetry_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        SEQ,
        DATA,
        CSUM
    } state_e;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    function automatic int bytesPerChannel(input int sampleW);
        return (sampleW + 7) / 8;
    endfunction

endpackage

// File: rtl/telemetry_framer.sv
// Packetises a snapshot of NCH sensor samples into a sync/seq/data/checksum
// byte stream with a registered valid/ready interface towards a UART TX.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int         NCH      = 3,
    parameter int         SAMPLE_W = 16,
    parameter logic [7:0] SYNC0    = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1    = SYNC1_DEFAULT
) (
    input  logic                    GCLK,
    input  logic                    RST_N,
    input  logic [NCH*SAMPLE_W-1:0] samples,
    input  logic                    frame_req,
    input  logic                    cont,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun,
    output logic [7:0]              seq
);

    localparam int BPC = bytesPerChannel(SAMPLE_W);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPC - 1);

    state_e                  state_q, state_d;
    logic [NCH*SAMPLE_W-1:0] snap_q, snap_d;
    logic [CW-1:0]           chIdx_q, chIdx_d;
    logic [BW-1:0]           byteIdx_q, byteIdx_d;
    logic [7:0]              csum_q, csum_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              txData_q, txData_d;
    logic                    txValid_q, txValid_d;
    logic                    frameDone_q, frameDone_d;
    logic                    overrun_q, overrun_d;
    logic                    accept, start, csumAccept;
    logic [7:0]              dataByte;

    // Sign-extend the chosen channel to a whole number of bytes, then pick one byte.
    function automatic logic [7:0] selectByte(input logic [NCH*SAMPLE_W-1:0] snap,
                                              input logic [CW-1:0] ch,
                                              input logic [BW-1:0] bi);
        logic [SAMPLE_W-1:0] s;
        logic [BPC*8-1:0]    ext;
        s   = snap[int'(ch)*SAMPLE_W +: SAMPLE_W];
        ext = (BPC*8)'($signed(s));
        return ext[int'(bi)*8 +: 8];
    endfunction

    assign accept     = txValid_q & tx_ready;
    assign start      = frame_req | cont;
    assign csumAccept = (state_q == CSUM) & accept;

    // tx_data always holds the byte of the state being entered, so every
    // acceptance is followed by the next byte without a bubble.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        chIdx_d     = chIdx_q;
        byteIdx_d   = byteIdx_q;
        csum_d      = csum_q;
        seq_d       = seq_q;
        txData_d    = txData_q;
        txValid_d   = txValid_q;
        frameDone_d = 1'b0;
        overrun_d   = frame_req & (state_q != IDLE) & ~csumAccept;
        dataByte    = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = HDR0;
                    snap_d    = samples;
                    txData_d  = SYNC0;
                    txValid_d = 1'b1;
                end
            end
            HDR0: begin
                if (accept) begin
                    state_d  = HDR1;
                    txData_d = SYNC1;
                end
            end
            HDR1: begin
                if (accept) begin
                    state_d  = SEQ;
                    txData_d = seq_q;
                    csum_d   = seq_q;
                end
            end
            SEQ: begin
                if (accept) begin
                    state_d   = DATA;
                    chIdx_d   = '0;
                    byteIdx_d = '0;
                    dataByte  = selectByte(snap_q, '0, '0);
                    txData_d  = dataByte;
                    csum_d    = csum_q + dataByte;
                end
            end
            DATA: begin
                if (accept) begin
                    if (byteIdx_q == LAST_BYTE && chIdx_q == LAST_CH) begin
                        state_d   = CSUM;
                        chIdx_d   = '0;
                        byteIdx_d = '0;
                        txData_d  = csum_q;
                    end else begin
                        if (byteIdx_q == LAST_BYTE) begin
                            byteIdx_d = '0;
                            chIdx_d   = chIdx_q + 1'b1;
                        end else begin
                            byteIdx_d = byteIdx_q + 1'b1;
                        end
                        dataByte = selectByte(snap_q, chIdx_d, byteIdx_d);
                        txData_d = dataByte;
                        csum_d   = csum_q + dataByte;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    frameDone_d = 1'b1;
                    seq_d       = seq_q + 8'd1;
                    if (start) begin
                        state_d  = HDR0;
                        snap_d   = samples;
                        txData_d = SYNC0;
                    end else begin
                        state_d   = IDLE;
                        txData_d  = 8'h00;
                        txValid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge GCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            chIdx_q     <= '0;
            byteIdx_q   <= '0;
            csum_q      <= 8'h00;
            seq_q       <= 8'h00;
            txData_q    <= 8'h00;
            txValid_q   <= 1'b0;
            frameDone_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            chIdx_q     <= chIdx_d;
            byteIdx_q   <= byteIdx_d;
            csum_q      <= csum_d;
            seq_q       <= seq_d;
            txData_q    <= txData_d;
            txValid_q   <= txValid_d;
            frameDone_q <= frameDone_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_data    = txData_q;
    assign tx_valid   = txValid_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frameDone_q;
    assign overrun    = overrun_q;
    assign seq        = seq_q;

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
- Packetises NCH parallel sensor samples (gyro/accel axes, temperature) into a framed byte stream for a byte-wide UART transmitter.
- Each frame carries:
  - a two-byte sync header
  - a sequence number
  - every channel, little-endian
  - an 8-bit additive checksum
- Sits between the sensor interface blocks and the UART TX. Replaces hand-written per-axis byte muxing with a parametrised, back-pressure-aware framer.

Parameters:
- NCH, 3, number of sample channels (1..8).
- SAMPLE_W, 16, width of each sample (1..32). BPC = ceil(SAMPLE_W/8) bytes per channel.
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.

Ports:
- GCLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- samples  in  NCH*SAMPLE_W  packed channel samples; channel 0 in the LSBs.
- frame_req  in  1  single-cycle request to send one frame.
- cont  in  1  continuous mode; when high, frames are sent back-to-back.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte this cycle.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse when the checksum byte is accepted.
- overrun  out  1  one-cycle pulse when frame_req is dropped.
- seq  out  8  sequence number of the current or next frame.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0, seq=0.
  - State returns to IDLE and the snapshot register clears.
- States: IDLE, HDR0, HDR1, SEQ, DATA, CSUM.
- Start condition: in IDLE, (frame_req | cont) at edge t.
  - All NCH samples are captured into the snapshot register at t.
  - Next state is HDR0; tx_valid=1 with tx_data=SYNC0 from t+1.
- Handshake:
  - A byte transfers on a rising edge where tx_valid & tx_ready.
  - tx_data and tx_valid are registered. There is no combinational path from tx_ready to either.
  - Once tx_valid rises, tx_data holds stable until accepted.
  - tx_valid never drops without acceptance, except on reset.
  - On acceptance, the next byte is presented in the following cycle with no bubble. Sustained throughput is one byte per cycle when tx_ready=1.
- Byte order: SYNC0, SYNC1, seq, then channel 0 byte 0 (LS) .. byte BPC-1, then channel 1, .., channel NCH-1, then checksum.
- Frame length = 4 + NCH*BPC bytes.
- Width rule: when SAMPLE_W is not a multiple of 8, the top byte is sign-extended from bit SAMPLE_W-1.
- Checksum: sum mod 256 of the seq byte and all data bytes. Sync bytes are excluded. It is accumulated as bytes are presented.
- DATA state counters:
  - byte index 0..BPC-1 within a channel
  - channel index 0..NCH-1
  - both wrap to 0 on leaving DATA
- Samples are read only from the snapshot. Input changes mid-frame do not affect the frame in progress.
- Completion (acceptance of the checksum byte):
  - frame_done pulses in the next cycle.
  - seq increments, wrapping 255->0.
- Back-to-back frames: if (cont | frame_req) is high in the same cycle the checksum is accepted, the next frame starts directly.
  - The snapshot is taken at that edge.
  - HDR0 is presented the next cycle with no IDLE cycle.
  - No overrun is raised.
- Otherwise the block returns to IDLE. busy=0 exactly when the state is IDLE.
- Overrun: frame_req high while busy, outside the checksum-acceptance cycle.
  - The request is dropped, not queued.
  - overrun pulses the next cycle.
  - The frame in progress is unaffected.
- cont deasserted mid-frame: the current frame completes; no new frame follows.

Decomposition:
- Shared package (telemetry_pkg):
  - state enum
  - default SYNC0/SYNC1 constants
  - a function computing BPC from SAMPLE_W
- Single module. Byte selection (channel/byte index into the snapshot, plus sign extension) is a local function, not a sub-module.

Test Plan:
- Basic frame: NCH=3, W=16, samples x=16'h1234, y=16'hABCD, z=16'h0001, seq=0, tx_ready=1, frame_req pulse. Required stream: A5 5A 00 34 12 CD AB 01 00 BF, 10 consecutive cycles; frame_done once; seq=1 afterwards.
- Back-pressure: same frame with tx_ready toggling pseudo-randomly. tx_data stays stable while tx_valid & ~tx_ready; the byte sequence is identical; samples changed mid-frame to 16'hFFFF do not alter the output.
- Continuous mode and wrap: cont=1 for 257 frames. No IDLE gap between frames; seq runs 00..FF then 00; checksum is correct in every frame.
- Overrun: frame_req pulsed during the DATA state. overrun pulses once and the frame is unchanged. A frame_req coincident with checksum acceptance starts the next frame with no overrun.
- Sign extension: NCH=1, W=12, sample 12'h800. Data bytes are 00 F8; checksum = seq+0x00+0xF8 mod 256.
- Reset mid-frame: RST_N low during DATA. tx_valid=0 and busy=0 immediately without waiting for a clock; seq=0. After release, a new frame_req yields a full frame starting with A5.
